levenshtein_search_engine: RTL
==============================

Name: levenshtein_search_engine

Overview:
- Parametrised successor to the bit-parallel (Myers) Levenshtein dictionary search controller.
- Sits between a Wishbone slave (host configuration/readback) and a Wishbone master (8-bit external memory holding the dictionary and the per-character match-vector table).
- Generalises bitvector, distance and index widths.
- Adds two search modes: best-match, and first-match-under-threshold with early stop.
- Adds a count of matching words, an abort path, and multi-byte vector fetch.

Parameters:
- MASTER_ADDR_WIDTH, 24, master byte-address width.
- SLAVE_ADDR_WIDTH, 24, slave address width; only bits [3:0] are decoded.
- BITVECTOR_WIDTH, 16, pattern bitvector width; must be a multiple of 8, max 32. VB = BITVECTOR_WIDTH/8.
- DISTANCE_WIDTH, 8, distance register width (max 8).
- ID_WIDTH, 16, word index and match counter width (max 16).

Ports:
- clk_i input 1: clock.
- rst_ni input 1: reset. Asynchronous assert, active-low; all state clears immediately.
- wbm_cyc_o output 1: master cycle.
- wbm_stb_o output 1: master strobe; always equal to wbm_cyc_o.
- wbm_adr_o output MASTER_ADDR_WIDTH: master byte address.
- wbm_we_o output 1: constant 0.
- wbm_dat_o output 8: constant 0.
- wbm_ack_i input 1: master ack.
- wbm_err_i input 1: master error.
- wbm_rty_i input 1: master retry; treated as an error.
- wbm_dat_i input 8: master read data.
- wbs_cyc_i, wbs_stb_i, wbs_we_i input 1 each: slave request.
- wbs_adr_i input SLAVE_ADDR_WIDTH: slave address.
- wbs_dat_i input 8: slave write data.
- wbs_ack_o output 1: slave ack.
- wbs_err_o, wbs_rty_o output 1 each: constant 0.
- wbs_dat_o output 8: slave read data, combinational on wbs_adr_i[3:0].

Behaviour:
- Register map (adr[3:0]):
  - 0 CTRL. Write: bit0 start, bit1 mode (0 best, 1 first). Read: {5'b0, found, error, busy}.
  - 1 LENGTH: word length, RW.
  - 2 THRESHOLD: RW.
  - 3 BEST_DISTANCE: RO.
  - 4/5 BEST_IDX hi/lo: RO, zero-extended to 16 bits.
  - 6/7 MATCH_COUNT hi/lo: RO.
  - 8+k MASK byte k (k < VB, byte 0 = LSB): RW.
  - 12+k INITIAL_VP byte k: RW.
  - Unmapped addresses read 0.
- Slave handshake:
  - wbs_ack_o pulses high for exactly 1 cycle, the cycle after cyc&stb is seen with ack low.
  - Back-to-back requests are therefore acked every 2 cycles.
- CTRL write with bit0=1 (also legal while busy; restarts the search):
  - Sets busy=1; clears error, found, idx, match_count and dict_address.
  - Sets best_distance to all-ones, best_idx=0, d=LENGTH, vp=INITIAL_VP, vn=0.
  - Enters FETCH_CHAR.
- CTRL write with bit0=0: abort.
  - busy=0; any open master cycle is dropped next cycle; results are retained.
- Reset values:
  - All master and slave outputs 0; state IDLE; busy, error and found 0.
  - best_distance all-ones; config registers 0.
- FSM states: IDLE, FETCH_CHAR, FETCH_VEC, UPDATE.
- Master access rules:
  - Each master access asserts cyc=stb the cycle after entering the fetch step.
  - cyc holds until ack/err/rty, then drops for at least 1 cycle; one byte per access.
- FETCH_CHAR:
  - Address = {1'b1, dict_address}; dict_address increments on ack.
  - Data 0xFF (end of dictionary): busy=0, go to IDLE.
  - Data 0xFE (end of word):
    - If d <= THRESHOLD, match_count increments, saturating at all-ones.
    - In mode 0: if d < best_distance (strict; ties keep the earliest word), update best_distance and best_idx.
    - In mode 1: if d <= THRESHOLD, record best_distance/best_idx, set found=1 and busy=0, go to IDLE. No further dictionary reads.
    - Otherwise (no stop): idx increments, d=LENGTH, vp=INITIAL_VP, vn=0, stay in FETCH_CHAR.
  - Any other byte c: latch it; go to FETCH_VEC with byte counter 0.
- FETCH_VEC:
  - Reads VB bytes at address c*VB + j, j = 0..VB-1, with MSB=0. Byte j=0 is the most significant byte of pm.
  - After the last ack, go to UPDATE.
- UPDATE (1 cycle, then back to FETCH_CHAR). All arithmetic is modulo BITVECTOR_WIDTH:
  - d0 = (((pm&vp)+vp)^vp)|pm|vn
  - hp = vn|~(d0|vp)
  - hn = d0&vp
  - If hp&mask != 0, d+1; else if hn&mask != 0, d-1.
  - Saturate d at all-ones and at 0.
  - vp <= (hn<<1)|~(d0|((hp<<1)|1))
  - vn <= d0&((hp<<1)|1)
- Master error: wbm_err_i or wbm_rty_i during an open cycle gives cyc=0, busy=0, error=1, state IDLE.
- Simultaneous slave CTRL write and master ack: the CTRL write wins; the ack data is discarded.

Test Plan:
- Pattern "a" (LENGTH=1, MASK=0x0001, INITIAL_VP=0x0001, vector['a']=0x0001, all others 0); dictionary "b",FE,"a",FE,FF; mode 0 -> BEST_IDX=1, BEST_DISTANCE=0, MATCH_COUNT=1 (THRESHOLD=0), busy=0, error=0.
- Same setup, mode 1, THRESHOLD=1 -> stops after word 0 with found=1, BEST_IDX=0, BEST_DISTANCE=1; no master read of address 0x800002 occurs.
- Dictionary FF only -> busy drops after one read; BEST_DISTANCE=0xFF, MATCH_COUNT=0.
- wbm_err_i asserted on the first vector read -> error=1, busy=0, wbm_cyc_o=0 the next cycle.
- CTRL write 0 mid-search, then CTRL write 1 -> second search results match a clean run; rst_ni pulse mid-cycle clears wbm_cyc_o asynchronously.
- BITVECTOR_WIDTH=32 build -> 4 vector reads per character at addresses c*4..c*4+3; results match a reference model.

Source files
------------

// File: rtl/levenshtein_search_engine.sv
// Myers bit-parallel Levenshtein dictionary search: host regs on a Wishbone slave, dictionary and vector table read one byte at a time over a Wishbone master.
// Slave acks one cycle after a request; each master byte waits for ack/err/rty, and one UPDATE cycle runs per dictionary character.
module levenshtein_search_engine #(
    parameter int MASTER_ADDR_WIDTH = 24,
    parameter int SLAVE_ADDR_WIDTH  = 24,
    parameter int BITVECTOR_WIDTH   = 16,
    parameter int DISTANCE_WIDTH    = 8,
    parameter int ID_WIDTH          = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    output logic                         wbm_cyc_o,
    output logic                         wbm_stb_o,
    output logic [MASTER_ADDR_WIDTH-1:0] wbm_adr_o,
    output logic                         wbm_we_o,
    output logic [7:0]                   wbm_dat_o,
    input  logic                         wbm_ack_i,
    input  logic                         wbm_err_i,
    input  logic                         wbm_rty_i,
    input  logic [7:0]                   wbm_dat_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [SLAVE_ADDR_WIDTH-1:0]  wbs_adr_i,
    input  logic [7:0]                   wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic                         wbs_err_o,
    output logic                         wbs_rty_o,
    output logic [7:0]                   wbs_dat_o
);
    localparam int MAW = MASTER_ADDR_WIDTH;
    localparam int BW  = BITVECTOR_WIDTH;
    localparam int DW  = DISTANCE_WIDTH;
    localparam int IW  = ID_WIDTH;
    localparam int VB  = BITVECTOR_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, FETCH_CHAR, FETCH_VEC, UPDATE} state_t;
    state_t state, state_nxt;

    logic [DW-1:0]  length_q, threshold_q, best_distance, d, d_upd;
    logic [BW-1:0]  mask, init_vp, vp, vn, pm;
    logic [BW-1:0]  d0, hp, hn, hp_sh, vp_new, vn_new;
    logic [IW-1:0]  best_idx, match_count, idx;
    logic [MAW-2:0] dict_address, vec_addr;
    logic [7:0]     chr;
    logic [1:0]     byte_cnt;
    logic           mode, error, found, busy;
    logic [3:0]     sadr;
    logic           slv_req, slv_wr, ctrl_wr, start, abort;
    logic           m_err, m_ack, is_eod, is_eow, hit, stop, last_byte, fetching;
    logic           unused_adr;

    assign sadr       = wbs_adr_i[3:0];
    assign unused_adr = ^wbs_adr_i[SLAVE_ADDR_WIDTH-1:4];
    assign slv_req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign slv_wr     = slv_req & wbs_we_i;
    assign ctrl_wr    = slv_wr & (sadr == 4'd0);
    assign start      = ctrl_wr & wbs_dat_i[0];
    assign abort      = ctrl_wr & ~wbs_dat_i[0];
    assign m_err      = wbm_cyc_o & (wbm_err_i | wbm_rty_i);
    assign m_ack      = wbm_cyc_o & wbm_ack_i & ~m_err;
    assign is_eod     = (wbm_dat_i == 8'hFF);
    assign is_eow     = (wbm_dat_i == 8'hFE);
    assign hit        = (d <= threshold_q);
    assign stop       = mode & hit;
    assign last_byte  = (byte_cnt == 2'(VB - 1));
    assign fetching   = (state == FETCH_CHAR) || (state == FETCH_VEC);
    assign busy       = (state != IDLE);
    assign vec_addr   = (MAW-1)'(chr) * (MAW-1)'(VB) + (MAW-1)'(byte_cnt);

    assign wbm_stb_o  = wbm_cyc_o;
    assign wbm_we_o   = 1'b0;
    assign wbm_dat_o  = 8'h00;
    assign wbs_err_o  = 1'b0;
    assign wbs_rty_o  = 1'b0;

    // One Myers column step; the |1 on hp_sh makes the top row a +1 edge, i.e. global distance.
    always_comb begin
        d0     = (((pm & vp) + vp) ^ vp) | pm | vn;
        hp     = vn | ~(d0 | vp);
        hn     = d0 & vp;
        hp_sh  = {hp[BW-2:0], 1'b1};
        vp_new = {hn[BW-2:0], 1'b0} | ~(d0 | hp_sh);
        vn_new = d0 & hp_sh;
        d_upd  = d;
        if (|(hp & mask)) begin
            if (d != '1) d_upd = d + 1'b1;
        end else if (|(hn & mask)) begin
            if (d != '0) d_upd = d - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = FETCH_CHAR;
        end else if (abort || m_err) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                FETCH_CHAR: if (m_ack) begin
                    if (is_eod || (is_eow && stop)) state_nxt = IDLE;
                    else if (!is_eow)               state_nxt = FETCH_VEC;
                end
                FETCH_VEC:  if (m_ack && last_byte) state_nxt = UPDATE;
                UPDATE:     state_nxt = FETCH_CHAR;
                default:    state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wbm_cyc_o <= 1'b0;  wbm_adr_o <= '0;      wbs_ack_o <= 1'b0;
            length_q <= '0;     threshold_q <= '0;    mask <= '0;  init_vp <= '0;
            mode <= 1'b0;       error <= 1'b0;        found <= 1'b0;
            best_distance <= '1; best_idx <= '0;      match_count <= '0; idx <= '0;
            dict_address <= '0; d <= '0;  vp <= '0;   vn <= '0;  pm <= '0;
            chr <= '0;          byte_cnt <= '0;
        end else begin
            wbs_ack_o <= slv_req;
            if (slv_wr) begin
                if (sadr == 4'd0) mode        <= wbs_dat_i[1];
                if (sadr == 4'd1) length_q    <= wbs_dat_i[DW-1:0];
                if (sadr == 4'd2) threshold_q <= wbs_dat_i[DW-1:0];
                for (int k = 0; k < VB; k++) begin
                    if (int'(sadr) == 8 + k)  mask[k*8 +: 8]    <= wbs_dat_i;
                    if (int'(sadr) == 12 + k) init_vp[k*8 +: 8] <= wbs_dat_i;
                end
            end
            // A CTRL write outranks whatever the master bus returns in the same cycle.
            if (start) begin
                wbm_cyc_o <= 1'b0;  error <= 1'b0;  found <= 1'b0;
                idx <= '0;  match_count <= '0;  dict_address <= '0;
                best_distance <= '1;  best_idx <= '0;
                d <= length_q;  vp <= init_vp;  vn <= '0;
            end else if (abort) begin
                wbm_cyc_o <= 1'b0;
            end else if (m_err) begin
                wbm_cyc_o <= 1'b0;
                error     <= 1'b1;
            end else begin
                if (m_ack) begin
                    wbm_cyc_o <= 1'b0;
                end else if (fetching && !wbm_cyc_o) begin
                    wbm_cyc_o <= 1'b1;
                    wbm_adr_o <= (state == FETCH_CHAR) ? {1'b1, dict_address} : {1'b0, vec_addr};
                end
                case (state)
                    FETCH_CHAR: if (m_ack) begin
                        dict_address <= dict_address + 1'b1;
                        if (is_eow) begin
                            if (hit && match_count != '1) match_count <= match_count + 1'b1;
                            if (stop) begin
                                best_distance <= d;
                                best_idx      <= idx;
                                found         <= 1'b1;
                            end else begin
                                if (!mode && d < best_distance) begin
                                    best_distance <= d;
                                    best_idx      <= idx;
                                end
                                idx <= idx + 1'b1;
                                d   <= length_q;
                                vp  <= init_vp;
                                vn  <= '0;
                            end
                        end else if (!is_eod) begin
                            chr      <= wbm_dat_i;
                            byte_cnt <= '0;
                            pm       <= '0;
                        end
                    end
                    FETCH_VEC: if (m_ack) begin
                        pm       <= (pm << 8) | BW'(wbm_dat_i);
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    UPDATE: begin
                        d  <= d_upd;
                        vp <= vp_new;
                        vn <= vn_new;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        logic [15:0] bi16, mc16;
        bi16      = 16'(best_idx);
        mc16      = 16'(match_count);
        wbs_dat_o = 8'h00;
        case (sadr)
            4'd0: wbs_dat_o = {5'b0, found, error, busy};
            4'd1: wbs_dat_o = 8'(length_q);
            4'd2: wbs_dat_o = 8'(threshold_q);
            4'd3: wbs_dat_o = 8'(best_distance);
            4'd4: wbs_dat_o = bi16[15:8];
            4'd5: wbs_dat_o = bi16[7:0];
            4'd6: wbs_dat_o = mc16[15:8];
            4'd7: wbs_dat_o = mc16[7:0];
            default: begin
                for (int k = 0; k < VB; k++) begin
                    if (int'(sadr) == 8 + k)  wbs_dat_o = mask[k*8 +: 8];
                    if (int'(sadr) == 12 + k) wbs_dat_o = init_vp[k*8 +: 8];
                end
            end
        endcase
    end
endmodule
